mem_stall_bridge: RTL and testbench
===================================

MEM_STALL_BRIDGE -- requirements
Module: mem_stall_bridge

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 32, data width.
REQ-003 Parameter TIMEOUT, default 15, maximum REQ-state cycles to wait for mem_ack (range 1..255).
REQ-004 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cpu_adr  input  ADDR_W  address from the processor datapath address mux.
REQ-007 cpu_wdata  input  DATA_W  store data from the processor.
REQ-008 cpu_we  input  1  write request, driven by the controller's MemWrite.
REQ-009 cpu_rd  input  1  read request, used for instruction fetch (IRWrite) and the load memory-read step.
REQ-010 cpu_rdata  output  DATA_W  registered read data returned to the processor.
REQ-011 stall  output  1  freezes the controller microsequencer and all processor enables while high.
REQ-012 mem_req  output  1  memory request strobe.
REQ-013 mem_we  output  1  memory write qualifier.
REQ-014 mem_adr  output  ADDR_W  memory address.
REQ-015 mem_wdata  output  DATA_W  memory write data.
REQ-016 mem_ack  input  1  memory completion, one cycle per transfer.
REQ-017 mem_rdata  input  DATA_W  read data; valid in the mem_ack cycle.
REQ-018 err  output  1  sticky timeout flag.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, REQ and DONE.
REQ-020 IDLE: if cpu_we|cpu_rd, latch cpu_adr, cpu_wdata and we=cpu_we, then go to REQ; otherwise stay in IDLE.
REQ-021 If cpu_we and cpu_rd are both high in IDLE, the write SHALL take priority and the read SHALL be dropped.
REQ-022 stall SHALL equal (IDLE & (cpu_we|cpu_rd)) | (state==REQ), combinationally.
REQ-023 In REQ, mem_req SHALL be 1, and mem_adr, mem_wdata and mem_we SHALL be driven from the latched values and held stable until the cycle after mem_ack.
REQ-024 Outside REQ, mem_req and mem_we SHALL be 0.
REQ-025 In REQ with mem_ack=1: for a read, capture mem_rdata into cpu_rdata; for a write, leave cpu_rdata unchanged; then go to DONE.
REQ-026 A wait counter (8 bit) SHALL clear on entry to REQ and increment each REQ cycle without mem_ack.
REQ-027 If the counter reaches TIMEOUT without mem_ack, then:
  - set err;
  - load cpu_rdata with 0 if the request was a read;
  - go to DONE.
REQ-028 DONE: stall=0 and cpu_rdata is valid; cpu_we and cpu_rd SHALL be ignored; next state is always IDLE.
REQ-029 cpu_rdata SHALL hold its value until the next read completes or times out.
REQ-030 mem_ack outside REQ SHALL be ignored; it has no effect on state, cpu_rdata or err.
REQ-031 Minimum request latency (zero-wait memory, ack in the first REQ cycle) SHALL be:
  - cycle 0: IDLE, stall=1;
  - cycle 1: REQ, ack;
  - cycle 2: DONE, stall=0.
REQ-032 err SHALL stay set until reset; further transfers SHALL proceed normally while err=1.

Reset
REQ-033 reset high at a posedge SHALL force:
  - state=IDLE, counter=0;
  - cpu_rdata=0, err=0;
  - latched address, data and we = 0.
  This applies in any state, including mid-REQ.
REQ-034 After a reset taken mid-REQ, mem_req SHALL be 0 from the following cycle, and no DONE cycle SHALL occur.
REQ-035 While reset is high, stall SHALL still follow REQ-022 using state IDLE.

Verification
REQ-036 Read, zero wait.
  - Stimulus: cpu_rd=1, cpu_adr=0x00000010; mem_ack in the first REQ cycle with mem_rdata=0xE04F000F.
  - Required: stall=1 for 2 cycles; mem_adr=0x10 during REQ; cpu_rdata=0xE04F000F in DONE; stall=0 in DONE.
REQ-037 Write, 3 wait states.
  - Stimulus: cpu_we=1, cpu_adr=0x57, cpu_wdata=0xDEADBEEF; mem_ack on the 4th REQ cycle.
  - Required: mem_req=1 and mem_we=1 for 4 cycles with address and data stable; stall=1 for 5 cycles; cpu_rdata unchanged.
REQ-038 Simultaneous requests.
  - Stimulus: cpu_we=1 and cpu_rd=1 with cpu_adr=0x60.
  - Required: a single write transaction (mem_we=1); no read issued; cpu_rdata unchanged.
REQ-039 Timeout.
  - Stimulus: TIMEOUT=4; read with no mem_ack.
  - Required: exactly 4 REQ cycles, then DONE with cpu_rdata=0 and err=1; err still 1 after a subsequent successful read.
REQ-040 Reset mid-transaction.
  - Stimulus: assert reset in the 2nd REQ cycle of a read.
  - Required: next cycle state=IDLE, mem_req=0, cpu_rdata=0, err=0; a mem_ack arriving one cycle later is ignored.
REQ-041 Back-to-back requests.
  - Stimulus: cpu_rd held high through DONE.
  - Required: no request is issued in DONE; a new transaction begins in the following IDLE cycle.

Source files
------------

// File: rtl/mem_stall_bridge.sv
// Stalls the multicycle processor while a single memory transfer is handed to a
// slow memory port. It also times out transfers that are never acknowledged.
module mem_stall_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_rd,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] adr_reg, adr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic              we_reg, we_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              err_reg, err_next;
    logic [7:0]        cnt_inc;
    state_t            stall_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            adr_reg   <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            cnt_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            adr_reg   <= adr_next;
            wdata_reg <= wdata_next;
            we_reg    <= we_next;
            cnt_reg   <= cnt_next;
            rdata_reg <= rdata_next;
            err_reg   <= err_next;
        end
    end

    assign cnt_inc = cnt_reg + 8'd1;

    always_comb begin
        state_next = state_reg;
        adr_next   = adr_reg;
        wdata_next = wdata_reg;
        we_next    = we_reg;
        cnt_next   = cnt_reg;
        rdata_next = rdata_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                // A write wins over a simultaneous read; the read is simply dropped.
                if (cpu_we || cpu_rd) begin
                    adr_next   = cpu_adr;
                    wdata_next = cpu_wdata;
                    we_next    = cpu_we;
                    cnt_next   = '0;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (!we_reg) rdata_next = mem_rdata;
                    state_next = DONE;
                end else if (cnt_inc == TIMEOUT_C) begin
                    cnt_next   = cnt_inc;
                    err_next   = 1'b1;
                    if (!we_reg) rdata_next = '0;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // While reset is asserted the stall decode behaves as if already in IDLE.
    assign stall_state = reset ? IDLE : state_reg;
    assign stall       = ((stall_state == IDLE) && (cpu_we || cpu_rd)) || (stall_state == REQ);

    assign mem_req   = (state_reg == REQ);
    assign mem_we    = (state_reg == REQ) && we_reg;
    assign mem_adr   = adr_reg;
    assign mem_wdata = wdata_reg;
    assign cpu_rdata = rdata_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_mem_stall_bridge.sv
// Directed and randomized transfers against a transaction-level model of the
// bridge: REQ cycle count, returned data and sticky error per transfer.
module tb_mem_stall_bridge;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] cpu_adr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic              cpu_rd;
    logic [DATA_W-1:0] cpu_rdata;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model_rdata;
    logic              model_err;

    mem_stall_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rd(cpu_rd),
        .cpu_rdata(cpu_rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic cycle_start();
        @(negedge clk);
    endtask

    // One complete transfer. ack_delay = number of REQ cycles without ack before
    // the ack; values >= TIMEOUT mean the memory never answers.
    task automatic do_txn(input string name, input logic we, input logic rd,
                          input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] wdata,
                          input int ack_delay, input logic [DATA_W-1:0] rdata,
                          input logic hold, input logic ack_in_done);
        int n_req;
        logic exp_we;
        exp_we = we;
        n_req  = (ack_delay < TIMEOUT) ? ack_delay + 1 : TIMEOUT;

        cycle_start();
        cpu_we = we; cpu_rd = rd; cpu_adr = adr; cpu_wdata = wdata; mem_ack = 1'b0;
        #1;
        chk({name, " idle_stall"}, stall, 1'b1);
        chk({name, " idle_req"}, mem_req, 1'b0);
        chk({name, " idle_rdata"}, cpu_rdata, model_rdata);
        chk({name, " idle_err"}, err, model_err);

        for (int k = 0; k < n_req; k++) begin
            cycle_start();
            cpu_adr   = $urandom;
            cpu_wdata = $urandom;
            mem_ack   = (k == ack_delay);
            mem_rdata = (k == ack_delay) ? rdata : DATA_W'($urandom);
            #1;
            chk({name, " req_stall"}, stall, 1'b1);
            chk({name, " req_req"}, mem_req, 1'b1);
            chk({name, " req_we"}, mem_we, exp_we);
            chk({name, " req_adr"}, mem_adr, adr);
            if (exp_we) chk({name, " req_wdata"}, mem_wdata, wdata);
        end

        if (!we) model_rdata = (ack_delay < TIMEOUT) ? rdata : '0;
        if (ack_delay >= TIMEOUT) model_err = 1'b1;

        cycle_start();
        mem_ack   = ack_in_done;
        mem_rdata = $urandom;
        if (!hold) begin cpu_we = 1'b0; cpu_rd = 1'b0; end
        #1;
        chk({name, " done_stall"}, stall, 1'b0);
        chk({name, " done_req"}, mem_req, 1'b0);
        chk({name, " done_rdata"}, cpu_rdata, model_rdata);
        chk({name, " done_err"}, err, model_err);
        $display("txn %s we=%0b rd=%0b adr=%08h ack_delay=%0d req_cycles=%0d rdata=%08h err=%0b",
                 name, we, rd, adr, ack_delay, n_req, cpu_rdata, err);
    endtask

    initial begin
        reset = 1'b1; cpu_we = 1'b0; cpu_rd = 1'b0; cpu_adr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        model_rdata = '0; model_err = 1'b0;

        repeat (2) cycle_start();
        cpu_rd = 1'b1;
        #1;
        chk("rst stall_follows_req", stall, 1'b1);
        cycle_start();
        reset = 1'b0; cpu_rd = 1'b0;
        #1;
        chk("rst stall", stall, 1'b0);
        chk("rst mem_req", mem_req, 1'b0);
        chk("rst mem_we", mem_we, 1'b0);
        chk("rst rdata", cpu_rdata, 32'h0);
        chk("rst err", err, 1'b0);
        chk("rst mem_adr", mem_adr, 32'h0);

        do_txn("read0",  1'b0, 1'b1, 32'h10, 32'h0,        0,   32'hE04F000F, 1'b0, 1'b0);
        do_txn("write3", 1'b1, 1'b0, 32'h57, 32'hDEADBEEF, 3,   32'h12345678, 1'b0, 1'b0);
        do_txn("both",   1'b1, 1'b1, 32'h60, 32'hCAFEF00D, 1,   32'h0BADBEEF, 1'b0, 1'b0);
        do_txn("tmo",    1'b0, 1'b1, 32'h80, 32'h0,        255, 32'h11111111, 1'b0, 1'b0);
        do_txn("rd_err", 1'b0, 1'b1, 32'h84, 32'h0,        2,   32'hA5A5A5A5, 1'b0, 1'b1);
        do_txn("b2b_a",  1'b0, 1'b1, 32'h90, 32'h0,        0,   32'h01020304, 1'b1, 1'b0);
        do_txn("b2b_b",  1'b0, 1'b1, 32'h94, 32'h0,        1,   32'h05060708, 1'b0, 1'b0);

        // Reset in the 2nd REQ cycle of a read, followed by a stray ack.
        cycle_start();
        cpu_rd = 1'b1; cpu_adr = 32'hA0; mem_ack = 1'b0;
        #1; chk("mid idle_stall", stall, 1'b1);
        cycle_start();
        #1; chk("mid req1", mem_req, 1'b1);
        cycle_start();
        reset = 1'b1; cpu_rd = 1'b0;
        #1;
        chk("mid req2", mem_req, 1'b1);
        chk("mid stall_in_reset", stall, 1'b0);
        cycle_start();
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
        model_rdata = '0; model_err = 1'b0;
        #1;
        chk("mid after mem_req", mem_req, 1'b0);
        chk("mid after stall", stall, 1'b0);
        chk("mid after rdata", cpu_rdata, model_rdata);
        chk("mid after err", err, model_err);
        chk("mid after adr", mem_adr, 32'h0);
        cycle_start();
        mem_ack = 1'b0;
        #1;
        chk("mid stray_ack mem_req", mem_req, 1'b0);
        chk("mid stray_ack rdata", cpu_rdata, model_rdata);
        chk("mid stray_ack err", err, model_err);
        $display("txn mid_reset adr=000000a0 rdata=%08h err=%0b", cpu_rdata, err);

        for (int i = 0; i < 40; i++) begin
            logic r_we, r_rd;
            int   sel;
            sel  = $urandom_range(0, 2);
            r_we = (sel != 0);
            r_rd = (sel != 1);
            do_txn($sformatf("rnd%0d", i), r_we, r_rd, $urandom, $urandom,
                   $urandom_range(0, 6), $urandom, 1'($urandom), 1'($urandom));
        end

        cycle_start();
        cpu_we = 1'b0; cpu_rd = 1'b0; mem_ack = 1'b0;
        #1;
        chk("final rdata", cpu_rdata, model_rdata);
        chk("final err", err, model_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
